// File: rtl/uart_rx_param.sv
// uart_rx_param: parametrised UART receive engine with its own bit timing.
//
// Parameters: WIDTH (5..9 data bits), CLKS_PER_BIT (>=4, even), PARITY
// (0 none / 1 even / 2 odd), STOP_BITS (1 or 2).
//
// Ports:
//   clk        in   single clock, rising edge
//   reset      in   asynchronous active-high reset
//   data       in   serial line, asynchronous, idles high
//   rx         out  received word, LSB = first data bit on the line
//   rx_valid   out  rx and error flags hold an unread frame
//   rx_ready   in   consumer accepts (transfer on rx_valid && rx_ready)
//   parity_err out  parity mismatch for the frame in rx
//   frame_err  out  a stop bit sampled low for the frame in rx
//   overrun    out  sticky: a completed frame was dropped
//   busy       out  receiver is inside a frame (not IDLE / WAIT_HIGH)
module uart_rx_param #(
  parameter int WIDTH        = 8,
  parameter int CLKS_PER_BIT = 868,
  parameter int PARITY       = 0,
  parameter int STOP_BITS    = 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             data,
  output logic [WIDTH-1:0] rx,
  output logic             rx_valid,
  input  logic             rx_ready,
  output logic             parity_err,
  output logic             frame_err,
  output logic             overrun,
  output logic             busy
);

  localparam int             BCW       = $clog2(CLKS_PER_BIT);
  localparam logic [BCW-1:0] BC_HALF   = BCW'(CLKS_PER_BIT/2 - 1);
  localparam logic [BCW-1:0] BC_FULL   = BCW'(CLKS_PER_BIT - 1);
  localparam logic [BCW-1:0] BC_ONE    = BCW'(1);
  localparam logic [3:0]     LAST_DATA = 4'(WIDTH - 1);
  localparam logic [3:0]     LAST_STOP = 4'(STOP_BITS - 1);

  typedef enum logic [2:0] {IDLE, START, DATA, PAR, STOP, WAIT_HIGH} state_t;

  state_t           state_q, state_d;
  logic             sync_q, ds_q;
  logic [BCW-1:0]   bc_q, bc_d;
  logic [3:0]       idx_q, idx_d;
  logic [WIDTH-1:0] sh_q, sh_d;
  logic             pe_q, pe_d;     // parity error of the frame being received
  logic             fe_q, fe_d;     // stop-bit error of the frame being received
  logic [WIDTH-1:0] rx_q, rx_d;
  logic             rx_valid_q, rx_valid_d;
  logic             parity_err_q, parity_err_d;
  logic             frame_err_q, frame_err_d;
  logic             overrun_q, overrun_d;
  logic             done;           // final stop sample taken this cycle
  logic             tick;

  always_comb begin
    state_d      = state_q;
    bc_d         = bc_q;
    idx_d        = idx_q;
    sh_d         = sh_q;
    pe_d         = pe_q;
    fe_d         = fe_q;
    rx_d         = rx_q;
    rx_valid_d   = rx_valid_q;
    parity_err_d = parity_err_q;
    frame_err_d  = frame_err_q;
    overrun_d    = overrun_q;
    done         = 1'b0;
    tick         = (bc_q == '0);

    case (state_q)
      IDLE: begin
        if (!ds_q) begin
          state_d = START;
          bc_d    = BC_HALF;
        end
      end
      START: begin
        if (!tick) begin
          bc_d = bc_q - BC_ONE;
        end else if (ds_q) begin
          state_d = IDLE;             // too short to be a start bit
        end else begin
          state_d = DATA;
          bc_d    = BC_FULL;
          idx_d   = '0;
          pe_d    = 1'b0;
          fe_d    = 1'b0;
        end
      end
      DATA: begin
        if (!tick) begin
          bc_d = bc_q - BC_ONE;
        end else begin
          sh_d = {ds_q, sh_q[WIDTH-1:1]};   // LSB arrives first
          bc_d = BC_FULL;
          if (idx_q == LAST_DATA) begin
            idx_d   = '0;
            state_d = (PARITY != 0) ? PAR : STOP;
          end else begin
            idx_d = idx_q + 4'd1;
          end
        end
      end
      PAR: begin
        if (!tick) begin
          bc_d = bc_q - BC_ONE;
        end else begin
          pe_d    = (PARITY == 2) ? ~(^sh_q ^ ds_q) : (^sh_q ^ ds_q);
          bc_d    = BC_FULL;
          state_d = STOP;
        end
      end
      STOP: begin
        if (!tick) begin
          bc_d = bc_q - BC_ONE;
        end else begin
          fe_d = fe_q | ~ds_q;
          bc_d = BC_FULL;
          if (idx_q == LAST_STOP) begin
            done    = 1'b1;
            // a low stop bit may be a break: wait for the line to recover
            state_d = fe_d ? WAIT_HIGH : IDLE;
          end else begin
            idx_d = idx_q + 4'd1;
          end
        end
      end
      WAIT_HIGH: begin
        if (ds_q) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    // output register: a completing frame wins over a plain transfer
    if (done && (!rx_valid_q || rx_ready)) begin
      rx_d         = sh_d;
      parity_err_d = pe_d;
      frame_err_d  = fe_d;
      rx_valid_d   = 1'b1;
    end else if (done) begin
      overrun_d = 1'b1;
    end else if (rx_valid_q && rx_ready) begin
      rx_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync_q       <= 1'b1;
      ds_q         <= 1'b1;
      state_q      <= IDLE;
      bc_q         <= '0;
      idx_q        <= '0;
      sh_q         <= '0;
      pe_q         <= 1'b0;
      fe_q         <= 1'b0;
      rx_q         <= '0;
      rx_valid_q   <= 1'b0;
      parity_err_q <= 1'b0;
      frame_err_q  <= 1'b0;
      overrun_q    <= 1'b0;
    end else begin
      sync_q       <= data;
      ds_q         <= sync_q;
      state_q      <= state_d;
      bc_q         <= bc_d;
      idx_q        <= idx_d;
      sh_q         <= sh_d;
      pe_q         <= pe_d;
      fe_q         <= fe_d;
      rx_q         <= rx_d;
      rx_valid_q   <= rx_valid_d;
      parity_err_q <= parity_err_d;
      frame_err_q  <= frame_err_d;
      overrun_q    <= overrun_d;
    end
  end

  assign rx         = rx_q;
  assign rx_valid   = rx_valid_q;
  assign parity_err = parity_err_q;
  assign frame_err  = frame_err_q;
  assign overrun    = overrun_q;
  assign busy       = (state_q != IDLE) && (state_q != WAIT_HIGH);

endmodule
